// File: rtl/beat_timing_gen.sv
// ---------------------------------------------------------------------------
// beat_timing_gen
// Beat and phase timing generator for the hardwired control path. Produces
// one-hot phase pulses T = {T3,T2,T1} (each PHASE_CYC MF clocks long) and the
// one-hot machine beat W = {W3,W2,W1}, stepping beats on SHORT/LONG/STOP
// requests returned by the control-signal decoder. Start/resume via QD.
//
// Parameters:
//   PHASE_CYC  MF clocks per phase, 1..15
// Ports:
//   MF     in   master clock (rising edge)
//   CLR    in   asynchronous active-low reset
//   QD     in   start key (asynchronous level, rising edge starts/resumes)
//   SHORT  in   in W1 at beat end: next beat W1
//   LONG   in   in W2 at beat end: next beat W3
//   STOP   in   at beat end: halt after the current beat
//   SSTEP  in   single-instruction step (only with BEAT_SSTEP_EN)
//   T      out  phase pulses, 000 while halted
//   W      out  current beat, held while halted
//   RUN    out  high while beats are generated
//
// Build option: define BEAT_SSTEP_EN to add the SSTEP input; with SSTEP high
// the block halts at every beat end whose next beat is W1.
// ---------------------------------------------------------------------------
module beat_timing_gen #(
  parameter int PHASE_CYC = 1
) (
  input  logic       MF,
  input  logic       CLR,
  input  logic       QD,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
`ifdef BEAT_SSTEP_EN
  input  logic       SSTEP,
`endif
  output logic [2:0] T,
  output logic [2:0] W,
  output logic       RUN
);

  typedef enum logic {S_HALT, S_RUN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(PHASE_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  t_q, t_d;
  logic [2:0]  w_q, w_d;
  logic [3:0]  cnt_q, cnt_d;
  // [0],[1]: 2-FF synchronizer; [2]: previous synchronized value for edge detect
  logic [2:0]  qd_sync_q, qd_sync_d;
  // Marks which qd_sync stages hold real samples since reset, so a QD already
  // high at CLR release is not mistaken for a rising edge.
  logic [2:0]  vld_pipe_q, vld_pipe_d;
  logic        qd_rise_q, qd_rise_d;
  logic [2:0]  w_next;
  logic        phase_last;
  logic        halt_req;

`ifdef BEAT_SSTEP_EN
  logic [1:0]  sstep_sync_q, sstep_sync_d;
`endif

  always_comb begin
    qd_sync_d  = {qd_sync_q[1:0], QD};
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
    qd_rise_d  = qd_sync_q[1] & ~qd_sync_q[2] & vld_pipe_q[2];
`ifdef BEAT_SSTEP_EN
    sstep_sync_d = {sstep_sync_q[0], SSTEP};
`endif

    // Next beat; any non-one-hot W recovers to W1.
    unique case (w_q)
      3'b001:  w_next = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_next = LONG  ? 3'b100 : 3'b001;
      default: w_next = 3'b001;
    endcase

`ifdef BEAT_SSTEP_EN
    halt_req = STOP | (sstep_sync_q[1] & (w_next == 3'b001));
`else
    halt_req = STOP;
`endif

    phase_last = (cnt_q == CNT_LAST);

    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_HALT: begin
        t_d   = 3'b000;
        cnt_d = 4'd0;
        if (qd_rise_q) begin
          state_d = S_RUN;
          t_d     = 3'b001;
        end
      end
      S_RUN: begin
        if (phase_last) begin
          cnt_d = 4'd0;
          if (t_q[2]) begin
            // Beat end: W and T change on the same edge.
            w_d = w_next;
            if (halt_req) begin
              state_d = S_HALT;
              t_d     = 3'b000;
            end else begin
              t_d = 3'b001;
            end
          end else if (t_q[1]) begin
            t_d = 3'b100;
          end else begin
            t_d = 3'b010;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge MF or negedge CLR) begin
    if (!CLR) begin
      state_q    <= S_HALT;
      t_q        <= 3'b000;
      w_q        <= 3'b001;
      cnt_q      <= 4'd0;
      qd_sync_q  <= 3'b000;
      vld_pipe_q <= 3'b000;
      qd_rise_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      qd_sync_q  <= qd_sync_d;
      vld_pipe_q <= vld_pipe_d;
      qd_rise_q  <= qd_rise_d;
    end
  end

`ifdef BEAT_SSTEP_EN
  always_ff @(posedge MF or negedge CLR) begin
    if (!CLR) sstep_sync_q <= 2'b00;
    else      sstep_sync_q <= sstep_sync_d;
  end
`endif

  assign T   = t_q;
  assign W   = w_q;
  assign RUN = (state_q == S_RUN);

endmodule

// File: tb/tb_beat_timing_gen.sv
// Bench for beat_timing_gen: directed literal checks plus a randomized run
// compared every cycle against a beat/position model of the generator.
module tb_beat_timing_gen;
  localparam int P = 2;

  logic mf = 1'b0;
  logic clr = 1'b0;
  logic qd = 1'b0, short_i = 1'b0, long_i = 1'b0, stop_i = 1'b0;
  logic sstep = 1'b0;
  logic [2:0] t_o, w_o;
  logic run_o;

  int total = 0;
  int bad = 0;

  always #5 mf = ~mf;

  beat_timing_gen #(.PHASE_CYC(P)) dut (
    .MF(mf), .CLR(clr), .QD(qd), .SHORT(short_i), .LONG(long_i), .STOP(stop_i),
`ifdef BEAT_SSTEP_EN
    .SSTEP(sstep),
`endif
    .T(t_o), .W(w_o), .RUN(run_o)
  );

  // ---- behavioural model: running flag, clock position within beat, beat number
  bit m_run = 0;
  int m_pos = 0;
  int m_w = 1;
  int m_k = 0;
  bit m_pend = 0;
  bit qh[$];
  bit sh[$];

  always @(posedge mf or negedge clr) begin
    if (!clr) begin
      m_run = 0; m_pos = 0; m_w = 1; m_k = 0; m_pend = 0;
      qh.delete(); sh.delete();
    end else begin
      bit start, halt;
      m_k = m_k + 1;
      qh.push_back(qd);
      sh.push_back(sstep);
      start = m_pend && !m_run;
      // rise seen by the block when QD sampled two edges ago is 1 and the one before is 0
      m_pend = (m_k >= 4) && qh[m_k-3] && !qh[m_k-4];
      if (m_run) begin
        if (m_pos == 3*P-1) begin
          m_w = (m_w == 1) ? (short_i ? 1 : 2) : (m_w == 2) ? (long_i ? 3 : 1) : 1;
          halt = stop_i;
`ifdef BEAT_SSTEP_EN
          if (m_k >= 3 && sh[m_k-3] && m_w == 1) halt = 1;
`endif
          if (halt) m_run = 0;
          m_pos = 0;
        end else m_pos = m_pos + 1;
      end else if (start) begin
        m_run = 1; m_pos = 0;
      end
    end
  end

  function automatic logic [2:0] exp_t();
    return m_run ? (3'b001 << (m_pos / P)) : 3'b000;
  endfunction
  function automatic logic [2:0] exp_w();
    return 3'b001 << (m_w - 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge mf) begin
    chk("model_T", {5'b0, t_o}, {5'b0, exp_t()});
    chk("model_W", {5'b0, w_o}, {5'b0, exp_w()});
    chk("model_RUN", {7'b0, run_o}, {7'b0, m_run});
  end

  task automatic nclk();
    @(negedge mf);
  endtask

  task automatic lit(input string nm, input logic [2:0] et, input logic [2:0] ew, input logic er);
    chk({nm, "_T"}, {5'b0, t_o}, {5'b0, et});
    chk({nm, "_W"}, {5'b0, w_o}, {5'b0, ew});
    chk({nm, "_RUN"}, {7'b0, run_o}, {7'b0, er});
  endtask

  // QD rising edge, then check the 4-clock start latency; ends at the T1 clock
  task automatic start_seq(input string nm, input logic [2:0] ew);
    #1 qd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      nclk();
      if (i < 4) lit(nm, 3'b000, ew, 1'b0);
      else       lit(nm, 3'b001, ew, 1'b1);
    end
  endtask

  logic [2:0] wseq [4];

  initial begin
    // reset with QD toggling
    for (int i = 0; i < 3; i++) begin
      nclk(); #1 qd = ~qd;
      lit("reset", 3'b000, 3'b001, 1'b0);
    end
    nclk(); #1 qd = 1'b1; clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nclk(); lit("qd_high_at_release", 3'b000, 3'b001, 1'b0);
    end

    // short loop
    #1 qd = 1'b0; short_i = 1'b1;
    nclk(); nclk();
    start_seq("short_start", 3'b001);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) nclk();
      lit("short_loop", 3'b001 << ((i / 2) % 3), 3'b001, 1'b1);
    end

    // long cycle from a fresh reset
    #1 clr = 1'b0; qd = 1'b0;
    nclk(); nclk();
    #1 clr = 1'b1; short_i = 1'b0; long_i = 1'b1;
    nclk();
    start_seq("long_start", 3'b001);
    wseq[0] = 3'b001; wseq[1] = 3'b010; wseq[2] = 3'b100; wseq[3] = 3'b001;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) nclk();
      lit("long_cycle", 3'b001 << ((i % 6) / 2), wseq[i / 6], 1'b1);
    end

    // halt during W2 T3 with LONG=0
    #1 long_i = 1'b0;
    for (int i = 24; i < 30; i++) nclk();
    #1 stop_i = 1'b1;
    nclk();
    #1 stop_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lit("halted", 3'b000, 3'b001, 1'b0);
      nclk();
    end
    #1 qd = 1'b0;
    nclk(); nclk(); nclk();
    start_seq("resume", 3'b001);

    // QD pulse while running must be ignored; reach W2 T2
    for (int j = 5; j <= 12; j++) begin
      nclk();
      if (j == 5) #1 qd = 1'b0;
      if (j == 6) #1 qd = 1'b1;
    end
    lit("w2t2", 3'b010, 3'b010, 1'b1);
    #1 clr = 1'b0;
    #1 lit("midbeat_reset", 3'b000, 3'b001, 1'b0);

    // SHORT and LONG both high in W1: SHORT wins
    nclk(); #1 clr = 1'b1; qd = 1'b0; short_i = 1'b1; long_i = 1'b1;
    nclk(); nclk();
    start_seq("prio_start", 3'b001);
    for (int i = 1; i < 12; i++) begin
      nclk();
      lit("prio", 3'b001 << ((i % 6) / 2), 3'b001, 1'b1);
    end

    // randomized run, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      nclk();
      #1;
      short_i = ($urandom % 4) == 0;
      long_i  = ($urandom % 3) == 0;
      stop_i  = ($urandom % 25) == 0;
      sstep   = ($urandom % 3) == 0;
      if (($urandom % 8) == 0) qd = ~qd;
      if (!clr) clr = 1'b1;
      else if (($urandom % 500) == 0) clr = 1'b0;
    end

    nclk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
